pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the 32-bit RISC core, successor to the single-register PC.
- Holds the fetch PC and generates the next PC from reset, trap, branch/jump redirect, sequential increment or halt/hold.
- Presents a PC-valid qualifier to the fetch stage.
- Sits between the branch/exception logic and the instruction-memory address port.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
- INC, 4, sequential increment in bytes; must be a power of two, at least 1.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN, must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- write_enable  in  1  advance PC by INC when no higher-priority event is present; low means stall.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  redirect destination.
- trap_req  in  1  exception/interrupt request.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc_out  out  XLEN  registered current PC.
- pc_next  out  XLEN  combinational value pc_out takes at the next edge.
- pc_valid  out  1  pc_out is a fetchable address this cycle.
- misaligned  out  1  registered one-cycle pulse: a redirect target had nonzero bits below log2(INC).
- state  out  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
Reset (rst=1 at an edge):
- pc_out=RESET_VECTOR, state=BOOT, pc_valid=0, misaligned=0.
- RAS is emptied.
- rst overrides every other input, including during HALT or mid-redirect.

BOOT:
- Lasts exactly one cycle; all inputs are ignored.
- pc_out stays RESET_VECTOR; the next state is RUN.
- The first valid fetch is the cycle after reset deasserts plus one.

RUN:
- pc_valid=1.
- Priority per edge: trap_req > redirect_valid > write_enable > hold.
- trap_req: pc_out is set to TRAP_VECTOR.
- redirect_valid: pc_out is set to redirect_target.
- Redirect with target[log2(INC)-1:0] != 0: pc_out is set to TRAP_VECTOR and misaligned pulses for one cycle.
- write_enable: pc_out is set to pc_out+INC, wrapping modulo 2^XLEN (e.g. 32'hFFFF_FFFC+4 gives 0).
- Otherwise pc_out holds.
- Trap and redirect take effect even when write_enable=0 (flush beats stall).
- halt_req with no trap: the next state is HALT. A redirect in the same cycle still loads its target; increment is suppressed.

HALT:
- pc_valid=0; pc_out holds.
- write_enable is ignored.
- redirect_valid updates pc_out (misalignment handling as in RUN) and the state stays HALT.
- trap_req loads TRAP_VECTOR and moves to RUN.
- resume: next state RUN with pc_out unchanged. resume together with redirect applies both.
- halt_req and resume together: resume wins.

General:
- pc_next always equals the value pc_out will hold after the next edge, assuming rst=0.
- Latency: any input affects pc_out exactly one edge later.
- state 11 is unreachable; if entered, the next state is BOOT with pc_out=RESET_VECTOR.

Optional Feature:
Macro PC_RAS_EN.

Defined:
- Adds ports call_push (in, 1), ret_pop (in, 1) and ras_underflow (out, 1, registered pulse).
- call_push in RUN, when the PC advances or holds: pushes pc_out+INC.
- Stack is circular: a push when full overwrites the oldest entry.
- ret_pop in RUN with no trap or redirect: pc_out is set to the top entry and the entry is popped. Priority is below redirect and above write_enable.
- Pop on empty: behaves as if ret_pop were absent and ras_underflow pulses.
- Push and pop together: pc_out is set to the old top, and the top is replaced by pc_out+INC (depth unchanged).
- trap_req does not alter the RAS. Reset empties it.

Undefined:
- No RAS logic and no extra ports; RAS_DEPTH is unused.

Test Plan:
1. Reset then run: rst high 2 cycles, release, write_enable=1. pc_out=0 at BOOT, then 0, 4, 8, 12 on successive RUN cycles; pc_valid rises one cycle after BOOT.
2. Stall versus redirect: write_enable=0 at pc=0x20 for 3 cycles, then redirect_valid=1 with target 0x400 and write_enable=0. pc stays 0x20 for 3 cycles, then becomes 0x400.
3. Priority and misalignment:
   - trap_req and redirect to 0x80 in the same cycle: pc=0x100.
   - Redirect to 0x82: pc=0x100 and misaligned=1 for exactly one cycle.
4. Wrap: force pc=32'hFFFF_FFF8 via redirect, write_enable=1. pc goes to 0xFFFF_FFFC, then 0x0000_0000.
5. Halt/resume: halt_req at pc=0x40, pulse write_enable for 5 cycles. pc stays 0x40 with pc_valid=0. Then redirect to 0x60 in HALT: pc=0x60, state still HALT. Then resume: RUN, next increment gives 0x64.
6. (PC_RAS_EN, RAS_DEPTH=2) RAS overflow and underflow:
   - call_push at pc 0x10, 0x20, 0x30.
   - ret_pop twice: pc goes to 0x34, then 0x24.
   - Third ret_pop: increments normally and ras_underflow=1 for one cycle.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with trap/redirect/halt control; optional return-address stack under PC_RAS_EN.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
`ifdef PC_RAS_EN
  input  logic            call_push,
  input  logic            ret_pop,
  output logic            ras_underflow,
`endif
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [1:0]      state
);
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);
  localparam logic [XLEN-1:0] MASK  = XLEN'(INC - 1);
  if (INC < 1 || (INC & (INC - 1)) != 0) begin : g_inc_chk
    $error("INC must be a power of two");
  end
  if (RAS_EN && RAS_DEPTH < 2) begin : g_ras_chk
    $error("RAS_DEPTH must be at least 2");
  end
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10, BAD = 2'b11} state_t;
  state_t          state_q, nxt_st;
  logic [XLEN-1:0] pc_q, nxt_pc, pc_inc, tgt_pc;
  logic            mis_q, nxt_mis, tgt_bad;
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   top, top_inc, top_dec;
  logic [CW-1:0]   cnt;
  logic            run_seq, push, pop_ok, uf_d, uf_q;
  assign run_seq = state_q == RUN && !trap_req && !redirect_valid;
  assign push    = run_seq && call_push;
  assign pop_ok  = run_seq && ret_pop && cnt != '0;
  assign uf_d    = run_seq && ret_pop && cnt == '0;
  assign top_inc = top == PW'(RAS_DEPTH - 1) ? '0 : top + 1'b1;
  assign top_dec = top == '0 ? PW'(RAS_DEPTH - 1) : top - 1'b1;
  assign ras_underflow = uf_q;
  // Push+pop in one cycle swaps the top entry in place so depth is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      top  <= '0;
      cnt  <= '0;
      uf_q <= 1'b0;
    end else begin
      uf_q <= uf_d;
      if (push && pop_ok) begin
        ras[top] <= pc_inc;
      end else if (push) begin
        ras[top_inc] <= pc_inc;
        top          <= top_inc;
        cnt          <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + 1'b1;
      end else if (pop_ok) begin
        top <= top_dec;
        cnt <= cnt - 1'b1;
      end
    end
  end
`endif
  always_comb begin
    pc_inc  = pc_q + INC_V;
    tgt_bad = |(redirect_target & MASK);
    tgt_pc  = tgt_bad ? TRAP_VECTOR : redirect_target;
    nxt_pc  = pc_q;
    nxt_st  = state_q;
    nxt_mis = 1'b0;
    case (state_q)
      BOOT: begin
        nxt_pc = RESET_VECTOR;
        nxt_st = RUN;
      end
      RUN: begin
        if (trap_req) begin
          nxt_pc = TRAP_VECTOR;
        end else if (redirect_valid) begin
          nxt_pc  = tgt_pc;
          nxt_mis = tgt_bad;
          nxt_st  = halt_req ? HALT : RUN;
        end
`ifdef PC_RAS_EN
        else if (pop_ok) begin
          nxt_pc = ras[top];
          nxt_st = halt_req ? HALT : RUN;
        end
`endif
        else if (halt_req) begin
          nxt_st = HALT;
        end else if (write_enable) begin
          nxt_pc = pc_inc;
        end
      end
      HALT: begin
        if (trap_req) begin
          nxt_pc = TRAP_VECTOR;
          nxt_st = RUN;
        end else begin
          nxt_pc  = redirect_valid ? tgt_pc : pc_q;
          nxt_mis = redirect_valid && tgt_bad;
          nxt_st  = resume ? RUN : HALT;
        end
      end
      default: begin
        nxt_pc = RESET_VECTOR;
        nxt_st = BOOT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      state_q <= BOOT;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= nxt_pc;
      state_q <= nxt_st;
      mis_q   <= nxt_mis;
    end
  end
  assign pc_out     = pc_q;
  assign pc_next    = nxt_pc;
  assign pc_valid   = state_q == RUN;
  assign misaligned = mis_q;
  assign state      = state_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit; driver queues expected post-edge values, monitor checks them.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_enable = 1'b0, redirect_valid = 1'b0, trap_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc_out, pc_next;
  logic        pc_valid, misaligned;
  logic [1:0]  state;
`ifdef PC_RAS_EN
  logic call_push = 1'b0, ret_pop = 1'b0, ras_underflow;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {logic [31:0] pc; logic [1:0] st; logic mis; logic chk_next;} exp_t;
  exp_t q[$];
  pc_unit dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_req(trap_req), .halt_req(halt_req), .resume(resume),
`ifdef PC_RAS_EN
    .call_push(call_push), .ret_pop(ret_pop), .ras_underflow(ras_underflow),
`endif
    .pc_out(pc_out), .pc_next(pc_next), .pc_valid(pc_valid), .misaligned(misaligned), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  // One vector per cycle: inputs applied just after an edge, result expected after the following edge.
  task automatic step(input logic r, input logic we, input logic rv, input logic [31:0] tgt,
                      input logic tr, input logic hq, input logic rs,
                      input logic [31:0] epc, input logic [1:0] est, input logic emis, input logic cn);
    @(posedge clk);
    #1;
    rst = r; write_enable = we; redirect_valid = rv; redirect_target = tgt;
    trap_req = tr; halt_req = hq; resume = rs;
    q.push_back('{pc: epc, st: est, mis: emis, chk_next: cn});
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
        if (e.chk_next) chk("pc_next", pc_next, e.pc);
        @(posedge clk);
        #2;
        e = q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.st == 2'b01});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    //    rst we rv tgt            tr hq rs  exp_pc         st    mis chk
    step(1, 0, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0);
    step(1, 0, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b01, 0, 1);
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 32'h0,        0, 0, 0, 32'(4 * i),     2'b01, 0, 1);
    repeat (3)
      step(0, 0, 0, 32'h0,        0, 0, 0, 32'h20,        2'b01, 0, 1);
    step(0, 0, 1, 32'h400,        0, 0, 0, 32'h400,       2'b01, 0, 1);
    step(0, 1, 1, 32'h80,         1, 0, 0, 32'h100,       2'b01, 0, 1);
    step(0, 1, 1, 32'h82,         0, 0, 0, 32'h100,       2'b01, 1, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h104,       2'b01, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFF8,  0, 0, 0, 32'hFFFF_FFF8, 2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'hFFFF_FFFC, 2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b01, 0, 1);
    step(0, 0, 1, 32'h40,         0, 0, 0, 32'h40,        2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 1, 0, 32'h40,        2'b10, 0, 1);
    repeat (5)
      step(0, 1, 0, 32'h0,        0, 0, 0, 32'h40,        2'b10, 0, 1);
    step(0, 0, 1, 32'h60,         0, 0, 0, 32'h60,        2'b10, 0, 1);
    step(0, 0, 0, 32'h0,          0, 0, 1, 32'h60,        2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h64,        2'b01, 0, 1);
    step(0, 1, 1, 32'h200,        0, 1, 0, 32'h200,       2'b10, 0, 1);
    step(0, 0, 1, 32'h300,        0, 1, 1, 32'h300,       2'b01, 0, 1);
    step(0, 0, 0, 32'h0,          0, 1, 0, 32'h300,       2'b10, 0, 1);
    step(0, 0, 0, 32'h0,          1, 0, 0, 32'h100,       2'b01, 0, 1);
    step(0, 0, 0, 32'h0,          0, 1, 0, 32'h100,       2'b10, 0, 1);
    step(0, 0, 1, 32'h101,        0, 0, 0, 32'h100,       2'b10, 1, 1);
    step(0, 1, 0, 32'h0,          0, 0, 1, 32'h100,       2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h104,       2'b01, 0, 1);
    step(0, 0, 0, 32'h0,          0, 1, 0, 32'h104,       2'b10, 0, 1);
    step(1, 1, 1, 32'h300,        0, 0, 0, 32'h0,         2'b00, 0, 0);
    step(0, 1, 1, 32'h500,        1, 0, 0, 32'h0,         2'b01, 0, 1);
    step(0, 1, 0, 32'h0,          0, 0, 0, 32'h4,         2'b01, 0, 1);
    step(0, 0, 0, 32'h0,          1, 0, 0, 32'h100,       2'b01, 0, 1);
    @(posedge clk);
    #1;
    write_enable = 1'b0; redirect_valid = 1'b0; trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #5;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
